// File: rtl/round_sgf_apply_if.sv
// round_sgf_apply_if: upstream/downstream handshake and data bundle for the rounding-apply stage
interface round_sgf_apply_if #(
    parameter int SW = 23,
    parameter int EW = 8
);
    logic          Valid_i;
    logic          Ready_o;
    logic [SW-1:0] Data_Sgf_i;
    logic [EW-1:0] Data_Exp_i;
    logic          Sign_i;
    logic          Round_Flag_i;
    logic          Valid_o;
    logic          Ready_i;
    logic [SW-1:0] Data_Sgf_o;
    logic [EW-1:0] Data_Exp_o;
    logic          Sign_o;
    logic          Overflow_o;

    modport master (
        output Valid_i, Data_Sgf_i, Data_Exp_i, Sign_i, Round_Flag_i, Ready_i,
        input  Ready_o, Valid_o, Data_Sgf_o, Data_Exp_o, Sign_o, Overflow_o
    );

    modport slave (
        input  Valid_i, Data_Sgf_i, Data_Exp_i, Sign_i, Round_Flag_i, Ready_i,
        output Ready_o, Valid_o, Data_Sgf_o, Data_Exp_o, Sign_o, Overflow_o
    );
endinterface

// File: rtl/round_sgf_apply.sv
// round_sgf_apply: 2-stage pipeline applying the round increment, renormalising on carry and flagging overflow
module round_sgf_apply #(
    parameter int SW = 23,
    parameter int EW = 8
) (
    input logic clk,
    input logic rst,
    round_sgf_apply_if.slave bus
);
    logic          v1, v2, sg1, sp1, adv1, adv2, special, inc, carry, ovf_n;
    logic [SW:0]   s1;
    logic [EW-1:0] e1, e_inc;

    assign adv2        = !v2 | bus.Ready_i;
    assign adv1        = !v1 | adv2;
    assign bus.Ready_o = adv1;
    assign bus.Valid_o = v2;

    // Inf/NaN inputs must never be incremented into a different encoding
    assign special = bus.Data_Exp_i == '1;
    assign inc     = bus.Round_Flag_i & !special;

    always_comb begin
        carry = s1[SW];
        e_inc = e1 + EW'(1);
        ovf_n = carry & !sp1 & (e_inc == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            s1  <= '0;
            e1  <= '0;
            sg1 <= 1'b0;
            sp1 <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.Valid_i;
            if (bus.Valid_i) begin
                s1  <= {1'b0, bus.Data_Sgf_i} + (SW+1)'(inc);
                e1  <= bus.Data_Exp_i;
                sg1 <= bus.Sign_i;
                sp1 <= special;
            end
        end
    end

    // On carry the low fraction bits are already zero (1.11..1 + ulp = 10.0..0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2             <= 1'b0;
            bus.Data_Sgf_o <= '0;
            bus.Data_Exp_o <= '0;
            bus.Sign_o     <= 1'b0;
            bus.Overflow_o <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                bus.Data_Sgf_o <= ovf_n ? '0 : s1[SW-1:0];
                bus.Data_Exp_o <= carry ? e_inc : e1;
                bus.Sign_o     <= sg1;
                bus.Overflow_o <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_round_sgf_apply.sv
// tb_round_sgf_apply: directed self-checking bench for round_sgf_apply
module tb_round_sgf_apply;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass = 0;
    int   total = 0;

    always #5 clk = ~clk;

    round_sgf_apply_if bus ();
    round_sgf_apply dut (.clk(clk), .rst(rst), .bus(bus));

    // {Valid_o, Data_Sgf_o, Data_Exp_o, Sign_o, Overflow_o}
    function automatic logic [33:0] obs();
        return {bus.Valid_o, bus.Data_Sgf_o, bus.Data_Exp_o, bus.Sign_o, bus.Overflow_o};
    endfunction

    task automatic drive(input logic v, input logic [22:0] s, input logic [7:0] e, input logic sg, input logic f);
        bus.Valid_i      = v;
        bus.Data_Sgf_i   = s;
        bus.Data_Exp_i   = e;
        bus.Sign_i       = sg;
        bus.Round_Flag_i = f;
    endtask

    task automatic run_one(input logic [22:0] s, input logic [7:0] e, input logic sg, input logic f,
                           output logic [33:0] mid, output logic [33:0] res);
        @(negedge clk);
        drive(1'b1, s, e, sg, f);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1 mid = obs();
        @(posedge clk);
        @(negedge clk);
        #1 res = obs();
    endtask

    task automatic test_reset;
        bus.Ready_i = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (obs() !== 34'h0) $display("FAIL reset_outputs got=%h exp=%h", obs(), 34'h0);
        else pass++;
        total++;
        if (bus.Ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.Ready_o);
        else pass++;
        rst = 1'b0;
    endtask

    task automatic test_round;
        logic [22:0] s[6];
        logic [7:0]  e[6];
        logic        sg[6], f[6];
        logic [33:0] ex[6];
        logic [33:0] mid, res;
        s  = '{23'h000001, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h400000, 23'h7FFFFF};
        e  = '{8'h80, 8'h7F, 8'h7F, 8'hFE, 8'hFF, 8'hFF};
        sg = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        f  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ex = '{{1'b1, 23'h000002, 8'h80, 1'b0, 1'b0},
               {1'b1, 23'h7FFFFF, 8'h7F, 1'b1, 1'b0},
               {1'b1, 23'h000000, 8'h80, 1'b0, 1'b0},
               {1'b1, 23'h000000, 8'hFF, 1'b0, 1'b1},
               {1'b1, 23'h400000, 8'hFF, 1'b1, 1'b0},
               {1'b1, 23'h7FFFFF, 8'hFF, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            run_one(s[i], e[i], sg[i], f[i], mid, res);
            total++;
            if (mid[33] !== 1'b0) $display("FAIL round%0d_latency valid_after_1=%b exp=0", i, mid[33]);
            else pass++;
            total++;
            if (res !== ex[i]) $display("FAIL round%0d_result got=%h exp=%h", i, res, ex[i]);
            else pass++;
        end
    endtask

    task automatic test_hold;
        logic [33:0] ex;
        ex = {1'b0, 23'h7FFFFF, 8'hFF, 1'b0, 1'b0};
        @(negedge clk);
        #1;
        total++;
        if (obs() !== ex) $display("FAIL idle_hold got=%h exp=%h", obs(), ex);
        else pass++;
    endtask

    task automatic test_back_to_back;
        logic [22:0] s[4];
        logic [7:0]  e[4];
        logic        sg[4], f[4];
        logic [32:0] ex[4];
        logic        ro_exp[10];
        logic [33:0] held;
        int          in_i, out_i;
        s  = '{23'h000010, 23'h7FFFFF, 23'h123456, 23'h7FFFFF};
        e  = '{8'h10, 8'h20, 8'h30, 8'hFE};
        sg = '{1'b0, 1'b0, 1'b1, 1'b0};
        f  = '{1'b1, 1'b1, 1'b0, 1'b1};
        ex = '{{23'h000011, 8'h10, 1'b0, 1'b0},
               {23'h000000, 8'h21, 1'b0, 1'b0},
               {23'h123456, 8'h30, 1'b1, 1'b0},
               {23'h000000, 8'hFF, 1'b0, 1'b1}};
        ro_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        in_i = 0;
        out_i = 0;
        held = '0;
        @(negedge clk);
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            bus.Ready_i = !(c >= 3 && c <= 6);
            if (in_i < 4) drive(1'b1, s[in_i], e[in_i], sg[in_i], f[in_i]);
            else drive(1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            if (c < 10) begin
                total++;
                if (bus.Ready_o !== ro_exp[c]) $display("FAIL btb_ready_c%0d got=%b exp=%b", c, bus.Ready_o, ro_exp[c]);
                else pass++;
            end
            if (c == 3) held = obs();
            if (c >= 4 && c <= 6) begin
                total++;
                if (obs() !== held || held[33] !== 1'b1) $display("FAIL btb_stall_c%0d got=%h exp=%h", c, obs(), held);
                else pass++;
            end
            if (c == 10) begin
                total++;
                if (bus.Valid_o !== 1'b0) $display("FAIL btb_drained got=%b exp=0", bus.Valid_o);
                else pass++;
            end
            if (bus.Valid_o && bus.Ready_i) begin
                if (out_i < 4) begin
                    total++;
                    if (obs() !== {1'b1, ex[out_i]}) $display("FAIL btb_out%0d got=%h exp=%h", out_i, obs(), {1'b1, ex[out_i]});
                    else pass++;
                end
                out_i++;
            end
            if (bus.Valid_i && bus.Ready_o) in_i++;
        end
        total++;
        if (out_i !== 4) $display("FAIL btb_out_count got=%0d exp=4", out_i);
        else pass++;
        total++;
        if (in_i !== 4) $display("FAIL btb_in_count got=%0d exp=4", in_i);
        else pass++;
    endtask

    task automatic test_reset_midstream;
        logic [33:0] mid, res;
        logic        stale;
        @(negedge clk);
        bus.Ready_i = 1'b0;
        drive(1'b1, 23'h7FFFFF, 8'hFE, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 23'h000005, 8'h40, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        total++;
        if (obs() !== {1'b1, 23'h0, 8'hFF, 1'b0, 1'b1}) $display("FAIL mid_prefill got=%h exp=%h", obs(), {1'b1, 23'h0, 8'hFF, 1'b0, 1'b1});
        else pass++;
        total++;
        if (bus.Ready_o !== 1'b0) $display("FAIL mid_full_ready got=%b exp=0", bus.Ready_o);
        else pass++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs() !== 34'h0) $display("FAIL mid_async_clear got=%h exp=%h", obs(), 34'h0);
        else pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.Ready_i = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1 stale = stale | bus.Valid_o;
        end
        total++;
        if (stale !== 1'b0) $display("FAIL mid_no_stale got=%b exp=0", stale);
        else pass++;
        run_one(23'h000003, 8'h01, 1'b1, 1'b1, mid, res);
        total++;
        if (res !== {1'b1, 23'h000004, 8'h01, 1'b1, 1'b0}) $display("FAIL mid_after_release got=%h exp=%h", res, {1'b1, 23'h000004, 8'h01, 1'b1, 1'b0});
        else pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
